oam_dma_arbiter: RTL



---
 rtl/oam_dma_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine and CPU/DMA memory port arbiter between sm83_core and the system bus.
// Build option: OAM_DMA_CPU_BLOCK_EN blocks non-HRAM CPU accesses during a transfer.
module oam_dma_arbiter #(
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter logic [15:0] OAM_BASE     = 16'hFE00,
    parameter int          DMA_LEN      = 160,
    parameter int          BYTE_PERIOD  = 4,
    parameter int          START_DELAY  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_r_addr,
    input  logic [15:0] cpu_w_addr,
    input  logic [7:0]  cpu_w_data,
    input  logic        cpu_w_wen,
    output logic [7:0]  cpu_r_data,
    output logic [15:0] mem_r_addr,
    output logic [15:0] mem_w_addr,
    output logic [7:0]  mem_w_data,
    output logic        mem_w_wen,
    input  logic [7:0]  mem_r_data,
    output logic        dma_active,
    output logic        dma_done
);

    // state | meaning
    // IDLE  | no transfer, full pass-through
    // SETUP | start delay after a DMA register write, CPU unblocked
    // XFER  | one byte copied every BYTE_PERIOD cycles on the period_cnt==0 slot
    typedef enum logic [1:0] {IDLE, SETUP, XFER} state_t;

    localparam int SETUP_CYC = START_DELAY * BYTE_PERIOD;
    localparam int SW        = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
    localparam int PW        = $clog2(BYTE_PERIOD);
    localparam logic [7:0]    LAST_IDX  = 8'(DMA_LEN - 1);
    localparam logic [PW-1:0] LAST_PER  = PW'(BYTE_PERIOD - 1);
    localparam logic [SW-1:0] SETUP_TOP = (SETUP_CYC > 0) ? SW'(SETUP_CYC - 1) : '0;

    state_t        state;
    logic [7:0]    dma_reg;
    logic [7:0]    idx;
    logic [PW-1:0] period_cnt;
    logic [SW-1:0] setup_cnt;

    logic       reg_wr;
    logic       reg_rd;
    logic       slot;
    logic [7:0] eff_hi;
    logic       r_blk;
    logic       w_blk;

    assign reg_wr = cpu_w_wen && (cpu_w_addr == DMA_REG_ADDR);
    assign reg_rd = (cpu_r_addr == DMA_REG_ADDR);
    assign slot   = (state == XFER) && (period_cnt == '0);
    // Echo RAM E000..FDFF mirrors C000..DDFF
    assign eff_hi = (dma_reg >= 8'hE0) ? (dma_reg - 8'h20) : dma_reg;

`ifdef OAM_DMA_CPU_BLOCK_EN
    function automatic logic cpu_allowed(input logic [15:0] addr);
        return ((addr >= 16'hFF80) && (addr <= 16'hFFFE)) || (addr == DMA_REG_ADDR);
    endfunction
    assign r_blk = (state == XFER) && !cpu_allowed(cpu_r_addr);
    assign w_blk = (state == XFER) && !cpu_allowed(cpu_w_addr);
`else
    assign r_blk = 1'b0;
    assign w_blk = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dma_reg    <= 8'h00;
            idx        <= 8'h00;
            period_cnt <= '0;
            setup_cnt  <= '0;
            dma_active <= 1'b0;
            dma_done   <= 1'b0;
        end else begin
            dma_done <= 1'b0;
            if (reg_wr) begin
                // A register write always (re)starts, even in a slot cycle
                dma_reg    <= cpu_w_data;
                idx        <= 8'h00;
                period_cnt <= '0;
                setup_cnt  <= SETUP_TOP;
                dma_active <= 1'b1;
                state      <= (SETUP_CYC == 0) ? XFER : SETUP;
            end else begin
                case (state)
                    IDLE: ;
                    SETUP: begin
                        if (setup_cnt == '0) begin
                            state      <= XFER;
                            period_cnt <= '0;
                        end else begin
                            setup_cnt <= setup_cnt - 1'b1;
                        end
                    end
                    XFER: begin
                        period_cnt <= (period_cnt == LAST_PER) ? '0 : period_cnt + 1'b1;
                        if (slot) begin
                            if (idx == LAST_IDX) begin
                                state      <= IDLE;
                                idx        <= 8'h00;
                                period_cnt <= '0;
                                dma_active <= 1'b0;
                                dma_done   <= 1'b1;
                            end else begin
                                idx <= idx + 8'h01;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        mem_r_addr = cpu_r_addr;
        mem_w_addr = cpu_w_addr;
        mem_w_data = cpu_w_data;
        mem_w_wen  = cpu_w_wen && !reg_wr && !w_blk;
        if (reg_rd) begin
            cpu_r_data = dma_reg;
        end else if (r_blk) begin
            cpu_r_data = 8'hFF;
        end else begin
            cpu_r_data = mem_r_data;
        end
        if (slot) begin
            mem_r_addr = {eff_hi, idx};
            mem_w_addr = OAM_BASE + {8'h00, idx};
            mem_w_data = mem_r_data;
            mem_w_wen  = 1'b1;
            if (!reg_rd) begin
                cpu_r_data = 8'hFF;
            end
        end
    end

endmodule
